fifo_write_arbiter: RTL and testbench
=====================================

FIFO_WRITE_ARBITER -- requirements
Module: fifo_write_arbiter

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
  WIDTH  8  data width, matches the FIFO write port.
  NUM_REQ  4  number of requesters, 2..16.
  MAX_BURST  16  maximum beats per grant, >=1.
REQ-002 Ports SHALL be, one per line: name  direction  width  meaning.
  clk  in  1  single clock, rising edge.
  rst_n  in  1  asynchronous active-low reset.
  req_valid  in  NUM_REQ  per-requester beat valid.
  req_data  in  NUM_REQ*WIDTH  per-requester data; requester k occupies bits [k*WIDTH +: WIDTH].
  req_last  in  NUM_REQ  per-requester end-of-packet flag, qualified by valid.
  req_ready  out  NUM_REQ  per-requester beat accepted this cycle.
  fifo_din  out  WIDTH  to FIFO din.
  fifo_wput  out  1  to FIFO wput.
  fifo_full  in  1  from FIFO full.
  grant_id  out  $clog2(NUM_REQ)  index of the current owner.
  busy  out  1  high while in state GRANT.

Function
REQ-003 The FSM SHALL have exactly two states: IDLE and GRANT.
REQ-004 In IDLE with any req_valid high, the FSM SHALL select a winner round-robin, starting at index (last_winner+1) mod NUM_REQ and searching upward with wrap. It SHALL register the winner into grant_id and move to GRANT on the next edge.
REQ-005 In IDLE, req_ready and fifo_wput SHALL be 0, and no data SHALL move.
REQ-006 In GRANT, beat acceptance SHALL be combinational:
  req_ready[grant_id] = ~fifo_full;
  all other req_ready bits = 0;
  fifo_wput = req_valid[grant_id] & ~fifo_full;
  fifo_din = req_data slice grant_id.
REQ-007 A beat SHALL be accepted only on a cycle with GRANT & req_valid[grant_id] & ~fifo_full. Each accepted beat SHALL increment the burst counter. The counter SHALL be $clog2(MAX_BURST+1) bits wide and SHALL be cleared on entry to GRANT.
REQ-008 GRANT SHALL return to IDLE on the edge after an accepted beat that has req_last=1, or after the accepted beat that brings the counter to MAX_BURST, whichever comes first. last_winner SHALL be updated to grant_id at that edge.
REQ-009 While fifo_full=1 in GRANT, the FSM SHALL hold grant_id, the counter, and the state unchanged. Full stalls never release the grant.
REQ-010 If the owner deasserts req_valid in GRANT, the grant SHALL be held; there is no timeout.
REQ-011 Requests arriving during GRANT SHALL be evaluated only in the next IDLE cycle. There is one mandatory bubble cycle between grants.
REQ-012 Best-case latency SHALL be: request seen in IDLE at cycle N, first beat accepted at cycle N+1.
REQ-013 A single requester asserting continuously SHALL be re-granted after each IDLE bubble.

Reset
REQ-014 While rst_n=0, outputs and state SHALL be:
  state=IDLE, grant_id=0, last_winner=NUM_REQ-1 (so requester 0 wins first), counter=0;
  req_ready=0, fifo_wput=0, fifo_din=0, busy=0.
REQ-015 Reset asserted mid-packet SHALL abandon the packet immediately. No beat SHALL be accepted in the cycle rst_n=0. Recovery SHALL start in IDLE after release.

Structure
REQ-016 The state enum (IDLE, GRANT) and the derived width functions SHALL live in the shared package fifo_arb_pkg.
REQ-017 The round-robin search SHALL be a combinational sub-module rr_picker. Inputs: request vector and last_winner. Outputs: winner index and any_req.
REQ-018 No clock-domain crossing SHALL exist inside this block. Its FIFO write side SHALL share clk.

Verification
REQ-019 The bench SHALL cover these directed scenarios:
  Reset release with req_valid=4'b1111 and all last=1: grants SHALL go 0,1,2,3,0, one beat each, with a one-cycle IDLE between grants.
  Requester 2 sends a 5-beat packet (last on beat 5), fifo_full=0: 5 consecutive wput cycles with data in order, then IDLE, then busy=0.
  Requester 1 with last never set, MAX_BURST=16: release after exactly 16 beats; requester 1 is re-granted only after other pending requesters are served.
  fifo_full=1 for 3 cycles mid-packet: wput=0 and req_ready=0 for those cycles, grant_id unchanged, no beat lost or duplicated.
  Owner drops valid for 2 cycles mid-packet while requester 0 is valid: grant stays with the owner; requester 0 is served only after the owner's last beat.
  rst_n pulsed low mid-packet: all outputs 0 during reset; after release, requester 0 wins first.

Source files
------------

// File: rtl/fifo_arb_pkg.sv
// Shared types and width helpers for the FIFO write arbiter.
package fifo_arb_pkg;

    // Arbiter FSM: waiting for a request, or streaming beats for one owner.
    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } arb_state_e;

    // Width of a requester index (at least one bit).
    function automatic int id_width(input int num_req);
        return (num_req > 1) ? $clog2(num_req) : 1;
    endfunction

    // Width of a burst counter able to hold the value max_burst.
    function automatic int cnt_width(input int max_burst);
        return $clog2(max_burst + 1);
    endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin search: first requester above last_i, with wrap.
module rr_picker
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IDW     = id_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDW-1:0]     last_i,
    output logic [IDW-1:0]     winner_o,
    output logic               any_req_o
);

    localparam logic [IDW-1:0] TOP_IDX = IDW'(NUM_REQ - 1);

    // Walk the ring starting one past the previous winner; the first hit wins.
    always_comb begin
        logic [IDW-1:0] idx;
        winner_o  = '0;
        any_req_o = 1'b0;
        idx       = last_i;
        for (int off = 0; off < NUM_REQ; off++) begin
            idx = (idx == TOP_IDX) ? '0 : idx + 1'b1;
            if (!any_req_o && req_i[idx]) begin
                winner_o  = idx;
                any_req_o = 1'b1;
            end else begin
                winner_o  = winner_o;
                any_req_o = any_req_o;
            end
        end
    end

endmodule

// File: rtl/fifo_write_arbiter.sv
// Round-robin arbiter that lets one requester at a time stream a packet
// (bounded by MAX_BURST beats) into a shared FIFO write port.
module fifo_write_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int NUM_REQ   = 4,
    parameter int MAX_BURST = 16
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NUM_REQ-1:0]          req_valid,
    input  logic [NUM_REQ*WIDTH-1:0]    req_data,
    input  logic [NUM_REQ-1:0]          req_last,
    output logic [NUM_REQ-1:0]          req_ready,
    output logic [WIDTH-1:0]            fifo_din,
    output logic                        fifo_wput,
    input  logic                        fifo_full,
    output logic [id_width(NUM_REQ)-1:0] grant_id,
    output logic                        busy
);

    localparam int IDW = id_width(NUM_REQ);
    localparam int CW  = cnt_width(MAX_BURST);
    localparam logic [CW-1:0]  BURST_END  = CW'(MAX_BURST);
    localparam logic [IDW-1:0] LAST_RESET = IDW'(NUM_REQ - 1);

    arb_state_e     state_q, state_d;
    logic [IDW-1:0] grant_q, grant_d;
    logic [IDW-1:0] last_q, last_d;
    logic [CW-1:0]  cnt_q, cnt_d;

    logic [IDW-1:0]   winner_s;
    logic             any_req_s;
    logic             owner_valid_s;
    logic             owner_last_s;
    logic [WIDTH-1:0] owner_data_s;
    logic             accept_s;
    logic [CW-1:0]    cnt_inc_s;
    logic             burst_done_s;

    rr_picker #(
        .NUM_REQ (NUM_REQ),
        .IDW     (IDW)
    ) u_picker (
        .req_i     (req_valid),
        .last_i    (last_q),
        .winner_o  (winner_s),
        .any_req_o (any_req_s)
    );

    // The current owner's lane; only meaningful while in GRANT.
    assign owner_valid_s = req_valid[grant_q];
    assign owner_last_s  = req_last[grant_q];
    assign owner_data_s  = req_data[int'(grant_q)*WIDTH +: WIDTH];

    // A beat moves only when the owner offers one and the FIFO has room.
    assign accept_s     = (state_q == ST_GRANT) & owner_valid_s & ~fifo_full;
    assign cnt_inc_s    = cnt_q + 1'b1;
    assign burst_done_s = owner_last_s | (cnt_inc_s == BURST_END);

    assign busy     = (state_q == ST_GRANT);
    assign grant_id = grant_q;

    // Next-state logic: pick a winner in IDLE, count beats and release in GRANT.
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (any_req_s) begin
                    state_d = ST_GRANT;
                    grant_d = winner_s;
                    cnt_d   = '0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_GRANT: begin
                // Full stalls and owner gaps simply hold everything.
                if (accept_s) begin
                    cnt_d = cnt_inc_s;
                    if (burst_done_s) begin
                        state_d = ST_IDLE;
                        last_d  = grant_q;
                    end else begin
                        state_d = ST_GRANT;
                    end
                end else begin
                    state_d = ST_GRANT;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Write-side outputs: steer the owner's lane to the FIFO during GRANT only.
    always_comb begin
        req_ready = '0;
        fifo_wput = 1'b0;
        fifo_din  = '0;
        if (state_q == ST_GRANT) begin
            req_ready[grant_q] = ~fifo_full;
            fifo_wput          = accept_s;
            fifo_din           = owner_data_s;
        end else begin
            req_ready = '0;
            fifo_wput = 1'b0;
            fifo_din  = '0;
        end
    end

    // State registers; reset leaves requester 0 first in line.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            grant_q <= '0;
            last_q  <= LAST_RESET;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Self-checking bench for fifo_write_arbiter: directed scenarios followed by
// randomized traffic, all compared against a packet-level reference model.
module tb_fifo_write_arbiter;

    localparam int W  = 8;
    localparam int N  = 4;
    localparam int MB = 16;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [N-1:0]     req_valid;
    logic [N*W-1:0]   req_data;
    logic [N-1:0]     req_last;
    logic [N-1:0]     req_ready;
    logic [W-1:0]     fifo_din;
    logic             fifo_wput;
    logic             fifo_full;
    logic [1:0]       grant_id;
    logic             busy;

    int checks = 0;
    int errors = 0;

    // Reference model: who owns the port, how many beats so far, previous winner.
    bit m_busy;
    int m_owner;
    int m_beats;
    int m_last;

    // Source model: beats left per requester, next data value, shaping knobs.
    int       rem[N];
    bit       nolast[N];
    bit       hold_off[N];
    bit       force_last;
    logic [W-1:0] seq[N];

    int           acc_owner[$];
    logic [W-1:0] acc_data[$];

    fifo_write_arbiter #(.WIDTH(W), .NUM_REQ(N), .MAX_BURST(MB)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_last  (req_last),
        .req_ready (req_ready),
        .fifo_din  (fifo_din),
        .fifo_wput (fifo_wput),
        .fifo_full (fifo_full),
        .grant_id  (grant_id),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive();
        for (int k = 0; k < N; k++) begin
            req_valid[k]        = (rem[k] > 0) && !hold_off[k];
            req_last[k]         = force_last || (!nolast[k] && rem[k] == 1);
            req_data[k*W +: W]  = seq[k];
        end
    endtask

    // One clock: drive at negedge, check at negedge+1, advance model at posedge.
    task automatic cycle();
        logic [N-1:0] e_ready;
        logic         e_wput;
        logic [W-1:0] e_din;
        logic [1:0]   e_gid;
        logic         e_busy;
        int           o;
        drive();
        #1;
        o       = m_owner;
        e_ready = '0;
        e_wput  = 1'b0;
        e_din   = '0;
        e_gid   = 2'd0;
        e_busy  = 1'b0;
        if (rst_n) begin
            e_gid  = 2'(m_owner);
            e_busy = m_busy;
            if (m_busy) begin
                e_din = seq[o];
                if (!fifo_full) begin
                    e_ready[o] = 1'b1;
                    e_wput     = (rem[o] > 0) && !hold_off[o];
                end
            end
        end
        chk("req_ready", 32'(req_ready), 32'(e_ready));
        chk("fifo_wput", 32'(fifo_wput), 32'(e_wput));
        chk("fifo_din",  32'(fifo_din),  32'(e_din));
        chk("grant_id",  32'(grant_id),  32'(e_gid));
        chk("busy",      32'(busy),      32'(e_busy));
        @(posedge clk);
        if (!rst_n) begin
            m_busy  = 1'b0;
            m_owner = 0;
            m_beats = 0;
            m_last  = N - 1;
        end else if (!m_busy) begin
            for (int off = 1; off <= N; off++) begin
                int c;
                c = (m_last + off) % N;
                if (!m_busy && req_valid[c]) begin
                    m_busy  = 1'b1;
                    m_owner = c;
                    m_beats = 0;
                end
            end
        end else if (e_wput) begin
            acc_owner.push_back(o);
            acc_data.push_back(seq[o]);
            m_beats++;
            if (req_last[o] || m_beats == MB) begin
                m_busy = 1'b0;
                m_last = o;
            end
            rem[o]--;
            seq[o] = seq[o] + 8'd1;
        end
        @(negedge clk);
    endtask

    task automatic run(input int n);
        repeat (n) cycle();
    endtask

    // Run until the model is idle with no traffic pending, bounded.
    task automatic drain();
        int guard;
        bit pending;
        guard = 0;
        pending = 1'b1;
        while (pending && guard < 300) begin
            cycle();
            guard++;
            pending = m_busy;
            for (int k = 0; k < N; k++) pending = pending || (rem[k] > 0);
        end
        if (pending) chk("drain_timeout", 32'd1, 32'd0);
    endtask

    task automatic clear_log();
        acc_owner.delete();
        acc_data.delete();
    endtask

    initial begin
        rst_n      = 1'b0;
        fifo_full  = 1'b0;
        force_last = 1'b0;
        req_valid  = '0;
        req_last   = '0;
        req_data   = '0;
        m_busy     = 1'b0;
        m_owner    = 0;
        m_beats    = 0;
        m_last     = N - 1;
        for (int k = 0; k < N; k++) begin
            rem[k]      = 0;
            nolast[k]   = 1'b0;
            hold_off[k] = 1'b0;
            seq[k]      = 8'(k * 64);
        end
        @(negedge clk);

        // All four request single-beat packets straight out of reset.
        force_last = 1'b1;
        rem[0] = 2; rem[1] = 1; rem[2] = 1; rem[3] = 1;
        run(2);
        rst_n = 1'b1;
        drain();
        force_last = 1'b0;
        chk("s1_count", 32'(acc_owner.size()), 32'd5);
        if (acc_owner.size() == 5) begin
            chk("s1_g0", 32'(acc_owner[0]), 32'd0);
            chk("s1_g1", 32'(acc_owner[1]), 32'd1);
            chk("s1_g2", 32'(acc_owner[2]), 32'd2);
            chk("s1_g3", 32'(acc_owner[3]), 32'd3);
            chk("s1_g4", 32'(acc_owner[4]), 32'd0);
        end
        clear_log();

        // Requester 2 sends a 5-beat packet.
        rem[2] = 5;
        drain();
        chk("s2_count", 32'(acc_owner.size()), 32'd5);
        for (int i = 0; i < acc_owner.size(); i++) begin
            chk("s2_owner", 32'(acc_owner[i]), 32'd2);
            chk("s2_data", 32'(acc_data[i]), 32'(acc_data[0] + 8'(i)));
        end
        run(1);
        chk("s2_idle", 32'(busy), 32'd0);
        clear_log();

        // Requester 1 never flags last: released at MAX_BURST, others go first.
        rem[1] = 32; nolast[1] = 1'b1;
        run(4);
        rem[0] = 1; rem[3] = 1;
        drain();
        nolast[1] = 1'b0;
        chk("s3_count", 32'(acc_owner.size()), 32'd34);
        if (acc_owner.size() == 34) begin
            chk("s3_b15", 32'(acc_owner[15]), 32'd1);
            chk("s3_b16", 32'(acc_owner[16]), 32'd3);
            chk("s3_b17", 32'(acc_owner[17]), 32'd0);
            chk("s3_b18", 32'(acc_owner[18]), 32'd1);
            chk("s3_b33", 32'(acc_owner[33]), 32'd1);
        end
        clear_log();

        // FIFO full for three cycles mid-packet.
        rem[2] = 6;
        run(3);
        fifo_full = 1'b1;
        run(3);
        fifo_full = 1'b0;
        drain();
        chk("s4_count", 32'(acc_owner.size()), 32'd6);
        for (int i = 0; i < acc_data.size(); i++)
            chk("s4_data", 32'(acc_data[i]), 32'(acc_data[0] + 8'(i)));
        clear_log();

        // Owner 3 pauses for two cycles while requester 0 waits.
        rem[3] = 4;
        run(3);
        hold_off[3] = 1'b1;
        rem[0] = 1;
        run(2);
        hold_off[3] = 1'b0;
        drain();
        chk("s5_count", 32'(acc_owner.size()), 32'd5);
        if (acc_owner.size() == 5) begin
            chk("s5_own3", 32'(acc_owner[3]), 32'd3);
            chk("s5_then0", 32'(acc_owner[4]), 32'd0);
        end
        clear_log();

        // Reset pulse mid-packet: requester 0 wins first afterwards.
        rem[2] = 5;
        run(3);
        clear_log();
        rem[0] = 1;
        rst_n = 1'b0;
        run(2);
        rst_n = 1'b1;
        drain();
        chk("s6_count", 32'(acc_owner.size()), 32'd4);
        if (acc_owner.size() == 4) begin
            chk("s6_first", 32'(acc_owner[0]), 32'd0);
            chk("s6_next", 32'(acc_owner[1]), 32'd2);
        end
        clear_log();

        // Randomized traffic with stalls, gaps and occasional over-long bursts.
        repeat (400) begin
            for (int k = 0; k < N; k++) begin
                if (rem[k] == 0 && ($urandom % 4) == 0) begin
                    rem[k]    = int'($urandom_range(1, 20));
                    nolast[k] = (($urandom % 6) == 0);
                end
                hold_off[k] = (($urandom % 8) == 0);
            end
            fifo_full = (($urandom % 4) == 0);
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
